// File: rtl/cnn_pkg.sv
// Shared constants, kernel/FC tables and FSM state type for the cnn_top block.
// Optional feature macro used by cnn_top: CNN_TOP_RELU_EN.
package cnn_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IMG_DIM  = 8;
  localparam int unsigned CONV_DIM = 6;
  localparam int unsigned POOL_DIM = 3;
  localparam int unsigned KSIZE    = 3;
  localparam int unsigned KTAPS    = KSIZE * KSIZE;
  localparam int unsigned NCONV    = CONV_DIM * CONV_DIM;
  localparam int unsigned NPOOL    = POOL_DIM * POOL_DIM;

  localparam logic signed [DATA_W-1:0] KERNEL [0:KTAPS-1] = '{
    32'sd1, 32'sd2, 32'sd1,
    32'sd2, 32'sd4, 32'sd2,
    32'sd1, 32'sd2, 32'sd1
  };

  localparam logic signed [DATA_W-1:0] FC_W [0:NPOOL-1] = '{
    32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd7, 32'sd8, 32'sd9
  };

  localparam logic signed [DATA_W-1:0] FC_B = 32'sd0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CONV,
    POOL,
    FC,
    DONE
  } state_t;

  // Signed maximum of two data words.
  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cnn_mac.sv
// Signed 32-bit multiply-accumulate with synchronous clear; the combinational
// sum exposes acc + a*b so the caller can capture a finished dot product.
module cnn_mac
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_sum_c
);

  logic signed [DATA_W-1:0] r_acc;
  logic signed [DATA_W-1:0] w_prod;

  assign w_prod  = i_a * i_b;
  assign o_sum_c = r_acc + w_prod;

  // Clear wins over accumulate so the final tap of a dot product restarts at zero.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum_c;
    end
  end

endmodule

// File: rtl/cnn_top.sv
// Tiny CNN: 8x8 image -> 3x3 conv -> optional ReLU -> 2x2 max pool -> 9-tap FC.
// Macro CNN_TOP_RELU_EN enables ReLU on conv outputs (default build stores them signed).
module cnn_top
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_SIZE  = 64,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic signed [DATA_W-1:0]    input_img [0:IMG_SIZE-1],
  output logic signed [OUT_WIDTH-1:0] value,
  output logic                        done
);

  localparam logic [1:0] K_LAST = 2'(KSIZE - 1);
  localparam logic [2:0] C_LAST = 3'(CONV_DIM - 1);
  localparam logic [1:0] P_LAST = 2'(POOL_DIM - 1);
  localparam logic [3:0] I_LAST = 4'(NPOOL - 1);

  state_t r_state;
  state_t w_next;

  logic signed [DATA_W-1:0] r_img  [0:IMG_SIZE-1];
  logic signed [DATA_W-1:0] r_conv [0:NCONV-1];
  logic signed [DATA_W-1:0] r_pool [0:NPOOL-1];

  logic [1:0] r_ki, r_kj;
  logic [2:0] r_row, r_col;
  logic [1:0] r_pr, r_pc;
  logic [3:0] r_pidx;

  logic                     w_tap_last, w_conv_last, w_idx_last;
  logic [5:0]               w_pix_row, w_pix_col, w_pix_idx, w_conv_idx, w_win;
  logic [3:0]               w_k_idx;
  logic signed [DATA_W-1:0] w_conv_val, w_pool_max;
  logic                     w_mac_clr, w_mac_en;
  logic signed [DATA_W-1:0] w_mac_a, w_mac_b, w_mac_sum;

  assign w_tap_last  = (r_ki == K_LAST) && (r_kj == K_LAST);
  assign w_conv_last = w_tap_last && (r_row == C_LAST) && (r_col == C_LAST);
  assign w_idx_last  = (r_pidx == I_LAST);

  assign w_pix_row  = 6'(r_row) + 6'(r_ki);
  assign w_pix_col  = 6'(r_col) + 6'(r_kj);
  assign w_pix_idx  = w_pix_row * 6'(IMG_DIM) + w_pix_col;
  assign w_k_idx    = 4'(r_ki) * 4'(KSIZE) + 4'(r_kj);
  assign w_conv_idx = 6'(r_row) * 6'(CONV_DIM) + 6'(r_col);
  assign w_win      = 6'(r_pr) * 6'(2 * CONV_DIM) + 6'(r_pc) * 6'(2);

`ifdef CNN_TOP_RELU_EN
  assign w_conv_val = w_mac_sum[DATA_W-1] ? '0 : w_mac_sum;
`else
  assign w_conv_val = w_mac_sum;
`endif

  assign w_pool_max = smax(smax(r_conv[w_win],                 r_conv[w_win + 6'd1]),
                           smax(r_conv[w_win + 6'(CONV_DIM)], r_conv[w_win + 6'(CONV_DIM + 1)]));

  // MAC operand steering: image x kernel during CONV, pool x weight during FC.
  always_comb begin
    w_mac_clr = 1'b0;
    w_mac_en  = 1'b0;
    w_mac_a   = '0;
    w_mac_b   = '0;
    case (r_state)
      LOAD: w_mac_clr = 1'b1;
      CONV: begin
        w_mac_en  = 1'b1;
        w_mac_clr = w_tap_last;
        w_mac_a   = KERNEL[w_k_idx];
        w_mac_b   = r_img[w_pix_idx];
      end
      FC: begin
        w_mac_en  = 1'b1;
        w_mac_clr = w_idx_last;
        w_mac_a   = FC_W[r_pidx];
        w_mac_b   = r_pool[r_pidx];
      end
      default: ;
    endcase
  end

  cnn_mac u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_mac_clr),
    .i_en    (w_mac_en),
    .i_a     (w_mac_a),
    .i_b     (w_mac_b),
    .o_sum_c (w_mac_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_next = LOAD;
      LOAD:    w_next = CONV;
      CONV:    if (w_conv_last) w_next = POOL;
      POOL:    if (w_idx_last) w_next = FC;
      FC:      if (w_idx_last) w_next = DONE;
      DONE:    if (!enable) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Data buffers need no reset: every run rewrites them before they are read.
  always_ff @(posedge clk) begin
    if (r_state == LOAD) begin
      for (int i = 0; i < int'(IMG_SIZE); i++) begin
        r_img[i] <= input_img[i];
      end
    end
    if (r_state == CONV && w_tap_last) begin
      r_conv[w_conv_idx] <= w_conv_val;
    end
    if (r_state == POOL) begin
      r_pool[r_pidx] <= w_pool_max;
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ki   <= '0;
      r_kj   <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_pr   <= '0;
      r_pc   <= '0;
      r_pidx <= '0;
      value  <= '0;
      done   <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_ki   <= '0;
          r_kj   <= '0;
          r_row  <= '0;
          r_col  <= '0;
          r_pr   <= '0;
          r_pc   <= '0;
          r_pidx <= '0;
        end
        CONV: begin
          if (r_kj == K_LAST) begin
            r_kj <= '0;
            if (r_ki == K_LAST) begin
              r_ki <= '0;
              if (r_col == C_LAST) begin
                r_col <= '0;
                r_row <= (r_row == C_LAST) ? 3'd0 : r_row + 3'd1;
              end else begin
                r_col <= r_col + 3'd1;
              end
            end else begin
              r_ki <= r_ki + 2'd1;
            end
          end else begin
            r_kj <= r_kj + 2'd1;
          end
        end
        POOL: begin
          r_pidx <= w_idx_last ? 4'd0 : r_pidx + 4'd1;
          if (r_pc == P_LAST) begin
            r_pc <= '0;
            r_pr <= (r_pr == P_LAST) ? 2'd0 : r_pr + 2'd1;
          end else begin
            r_pc <= r_pc + 2'd1;
          end
        end
        FC: begin
          r_pidx <= w_idx_last ? 4'd0 : r_pidx + 4'd1;
          if (w_idx_last) begin
            value <= OUT_WIDTH'(w_mac_sum + FC_B);
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!enable) done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_top.sv
// Scoreboard bench for cnn_top: fixed images with known results, random images
// against a behavioural model, restart handshake and mid-run reset.
module tb_cnn_top;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [31:0] img [0:63];
  logic signed [31:0] value;
  logic               done;

  int n_checks = 0;
  int n_errors = 0;
  logic signed [31:0] sb_q [$];

  always #5 clk = ~clk;

  cnn_top #(.IMG_SIZE(64), .OUT_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .input_img (img),
    .value     (value),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  function automatic logic signed [31:0] model_cnn();
    logic signed [31:0] cm [0:5][0:5];
    logic signed [31:0] acc, m;
    int k;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        acc = 0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            k = ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1);
            acc = acc + 32'(k) * img[(r + i) * 8 + c + j];
          end
        end
`ifdef CNN_TOP_RELU_EN
        if (acc < 0) acc = 0;
`endif
        cm[r][c] = acc;
      end
    end
    acc = 0;
    for (int p = 0; p < 9; p++) begin
      m = cm[2 * (p / 3)][2 * (p % 3)];
      if (cm[2 * (p / 3)][2 * (p % 3) + 1] > m) m = cm[2 * (p / 3)][2 * (p % 3) + 1];
      if (cm[2 * (p / 3) + 1][2 * (p % 3)] > m) m = cm[2 * (p / 3) + 1][2 * (p % 3)];
      if (cm[2 * (p / 3) + 1][2 * (p % 3) + 1] > m) m = cm[2 * (p / 3) + 1][2 * (p % 3) + 1];
      acc = acc + 32'(p + 1) * m;
    end
    return acc;
  endfunction

  task automatic fill_img(input logic signed [31:0] v);
    for (int i = 0; i < 64; i++) img[i] = v;
  endtask

  // One run: push expectation, start, wiggle enable and image mid-run, compare at done,
  // hold enable for a few cycles, then drop it and confirm done clears.
  task automatic run_and_check(input string tag, input logic signed [31:0] exp, input int hold);
    int cycles;
    bit got;
    logic signed [31:0] want;
    sb_q.push_back(exp);
    @(negedge clk);
    enable = 1'b1;
    cycles = 0;
    got = 1'b0;
    while (cycles < 400 && !got) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 3) begin
        for (int i = 0; i < 64; i++) img[i] = $urandom;
        enable = 1'b0;
      end
      if (cycles == 20) enable = 1'b1;
      if (done) got = 1'b1;
    end
    check({tag, " latency"}, 32'(cycles - 1), 32'd343);
    want = sb_q.pop_front();
    if (got) begin
      check({tag, " value"}, value, want);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        check({tag, " done held"}, 32'(done), 32'd1);
      end
      check({tag, " value held"}, value, want);
    end
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " done drop"}, 32'(done), 32'd0);
    check({tag, " value kept"}, value, want);
  endtask

  initial begin
    int seen;
    logic signed [31:0] exp_neg;
    rst = 1'b1;
    enable = 1'b0;
    fill_img(32'sd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset done", 32'(done), 32'd0);
    check("reset value", value, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle done", 32'(done), 32'd0);

    fill_img(32'sd1);
    run_and_check("ones", 32'sd720, 3);
    fill_img(32'sd1);
    run_and_check("ones restart", 32'sd720, 1);

    fill_img(32'sd0);
    img[27] = 32'sd1;
    run_and_check("impulse", 32'sd33, 1);

`ifdef CNN_TOP_RELU_EN
    exp_neg = 32'sd0;
`else
    exp_neg = -32'sd720;
`endif
    fill_img(-32'sd1);
    run_and_check("minus one", exp_neg, 1);

    // Mid-run reset: abort during CONV, expect no done and a cleared result.
    fill_img(32'sd1);
    @(negedge clk);
    enable = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("midrun no done", 32'(seen), 32'd0);
    check("midrun value", value, 32'd0);

    fill_img(32'sd1);
    run_and_check("ones after reset", 32'sd720, 1);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 64; i++) img[i] = 32'($signed($urandom_range(200, 0)) - 100);
      run_and_check("random small", model_cnn(), 1);
    end
    for (int i = 0; i < 64; i++) img[i] = $urandom;
    run_and_check("random wide", model_cnn(), 1);

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
